nor_vector_driver: RTL and testbench
====================================

NOR_VECTOR_DRIVER -- requirements
Module: nor_vector_driver

Interface
REQ-001 Parameter HOLD_CYCLES, default 1: cycles each input vector is held; legal range 1..255.
REQ-002 Parameter NUM_PASSES, default 1: full 4-vector sweeps per run; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  run request; sampled in IDLE and DONE only.
REQ-006 y  input  1  output of the downstream nor_gate under test.
REQ-007 a  output  1  registered operand A, drives nor_gate input a.
REQ-008 b  output  1  registered operand B, drives nor_gate input b.
REQ-009 busy  output  1  high while in DRIVE.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  valid when done=1: high iff err_count==0.
REQ-012 err_count  output  8  mismatches in the current or last run, saturating.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE and DONE.
REQ-014 IDLE to DRIVE on start=1; the first vector appears on a/b in the cycle after start is sampled.
REQ-015 Vector order {a,b} SHALL be 00, 10, 11, 01, repeated NUM_PASSES times.
REQ-016 Each vector SHALL be held exactly HOLD_CYCLES cycles.
REQ-017 A single run SHALL stay in DRIVE for exactly 4*HOLD_CYCLES*NUM_PASSES cycles.
REQ-018 y SHALL be sampled on the rising edge that ends a vector's last hold cycle.
REQ-019 y SHALL be compared with ~(a|b) at that sample point.
REQ-020 Each mismatch SHALL increment err_count, saturating at 255.
REQ-021 After the last sample, DRIVE to DONE; a=b=0 in DONE and IDLE.
REQ-022 start in DRIVE SHALL be ignored.
REQ-023 start in DONE SHALL clear err_count and re-enter DRIVE at vector 00, pass 0.
REQ-024 Hold counter width SHALL be 8 bits and pass counter width SHALL be 8 bits.
REQ-025 Vector index SHALL be 2 bits; it wraps 3 to 0 and increments the pass counter.

Reset
REQ-026 rst_n low SHALL immediately force IDLE and clear all counters.
REQ-027 rst_n low SHALL immediately force a=0, b=0, busy=0, done=0 and err_count=0; pass reads 1 but is meaningful only when done=1.
REQ-028 Reset asserted mid-run SHALL abort the run; after release, the block waits in IDLE for start.

Configuration
REQ-029 With NOR_DRV_CHECK_EN defined, the compare and err_count logic of REQ-018 to REQ-020 SHALL be compiled in.
REQ-030 Without NOR_DRV_CHECK_EN, y SHALL be unused, err_count tied to 0 and pass tied to 1.
REQ-031 Sequencing and timing SHALL be identical in both builds.

Structure
REQ-032 Package nor_drv_pkg SHALL hold the state enum (IDLE/DRIVE/DONE), the 4-entry vector table constant and the ERR_MAX=255 constant.
REQ-033 Checker logic SHALL be a sub-module nor_drv_checker (inputs clk, rst_n, sample, clear, a, b, y; output err_count).
REQ-034 nor_drv_checker SHALL be instantiated only under NOR_DRV_CHECK_EN.

Verification
REQ-035 Reset: rst_n=0 with any state -> a=0, b=0, busy=0, done=0, err_count=0 without waiting for clk.
REQ-036 HOLD=1, PASSES=1, real nor_gate: start pulse -> {a,b}=00,10,11,01 on 4 consecutive cycles, busy=1 for 4 cycles, then done=1, pass=1, err_count=0.
REQ-037 y stuck at 0, defaults -> err_count=1 (vector 00 only), pass=0; y=~nor for PASSES=100 -> err_count=255 (saturated).
REQ-038 HOLD=3, PASSES=2 -> a/b change every 3 cycles, busy high exactly 24 cycles, done follows.
REQ-039 rst_n pulsed low on the 2nd DRIVE cycle -> outputs clear immediately; start after release -> sequence restarts at 00.
REQ-040 start held high through DRIVE -> no restart; start in DONE with err_count=1 -> err_count=0 and new run begins at 00.

Source files
------------

// File: rtl/nor_drv_pkg.sv
// +--------------------------------------------------------------------+
// | nor_drv_pkg : shared types and constants for nor_vector_driver      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package nor_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Vector table {a,b}: entry 0 in the low bits -> 00, 10, 11, 01.
  localparam logic [7:0] VEC_TABLE = {2'b01, 2'b11, 2'b10, 2'b00};
  localparam logic [7:0] ERR_MAX   = 8'd255;

  function automatic logic [1:0] vec_at(input logic [1:0] idx);
    return VEC_TABLE[{idx, 1'b0} +: 2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/nor_drv_checker.sv
// +--------------------------------------------------------------------+
// | nor_drv_checker : compares y against ~(a|b), saturating err count   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module nor_drv_checker
  import nor_drv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample,
  input  logic       clear,
  input  logic       a,
  input  logic       b,
  input  logic       y,
  output logic [7:0] err_count
);

  logic [7:0] r_err;
  logic       w_mismatch;

  assign w_mismatch = sample && (y != ~(a | b));

  // Clear wins over a coincident sample: a new run starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 8'd0;
    end else if (clear) begin
      r_err <= 8'd0;
    end else if (w_mismatch && (r_err != ERR_MAX)) begin
      r_err <= r_err + 8'd1;
    end
  end

  assign err_count = r_err;

endmodule

`default_nettype wire

// File: rtl/nor_vector_driver.sv
// +--------------------------------------------------------------------+
// | nor_vector_driver : sweeps {a,b} through 00,10,11,01 on a NOR gate  |
// | Optional checker enabled by macro NOR_DRV_CHECK_EN.  Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module nor_vector_driver
  import nor_drv_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int NUM_PASSES  = 1
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] PASS_LAST = 8'(NUM_PASSES - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_hold, w_hold_nxt;
  logic [7:0] r_pass, w_pass_nxt;
  logic [1:0] r_vec, w_vec_nxt;
  logic [1:0] r_ab, w_ab_nxt;
  logic       w_launch;
  logic       w_sample;
  logic       w_clear;
  logic [7:0] w_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hold  <= 8'd0;
      r_pass  <= 8'd0;
      r_vec   <= 2'd0;
      r_ab    <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_pass  <= w_pass_nxt;
      r_vec   <= w_vec_nxt;
      r_ab    <= w_ab_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_pass_nxt  = r_pass;
    w_vec_nxt   = r_vec;
    w_ab_nxt    = r_ab;
    w_launch    = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_launch    = 1'b1;
          w_state_nxt = DRIVE;
          w_hold_nxt  = 8'd0;
          w_pass_nxt  = 8'd0;
          w_vec_nxt   = 2'd0;
          w_ab_nxt    = vec_at(2'd0);
        end
      end
      DRIVE: begin
        // The edge ending a vector's last hold cycle samples y and advances.
        if (r_hold == HOLD_LAST) begin
          w_sample   = 1'b1;
          w_hold_nxt = 8'd0;
          if ((r_vec == 2'd3) && (r_pass == PASS_LAST)) begin
            w_state_nxt = DONE;
            w_ab_nxt    = 2'b00;
            w_vec_nxt   = 2'd0;
            w_pass_nxt  = 8'd0;
          end else begin
            w_vec_nxt = r_vec + 2'd1;
            w_ab_nxt  = vec_at(r_vec + 2'd1);
            if (r_vec == 2'd3) begin
              w_pass_nxt = r_pass + 8'd1;
            end
          end
        end else begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_clear = w_launch;

`ifdef NOR_DRV_CHECK_EN
  nor_drv_checker u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample    (w_sample),
    .clear     (w_clear),
    .a         (r_ab[1]),
    .b         (r_ab[0]),
    .y         (y),
    .err_count (w_err_count)
  );
`else
  logic [2:0] w_unused_chk;
  assign w_unused_chk = {y, w_sample, w_clear};
  assign w_err_count  = 8'd0;
`endif

  assign a         = r_ab[1];
  assign b         = r_ab[0];
  assign busy      = (r_state == DRIVE);
  assign done      = (r_state == DONE);
  assign err_count = w_err_count;
  assign pass      = (w_err_count == 8'd0);

endmodule

`default_nettype wire

// File: tb/tb_nor_vector_driver.sv
// +--------------------------------------------------------------------+
// | tb_nor_vector_driver : randomized self-checking bench, three DUTs   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_nor_vector_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       st     [3];
  logic       y_d    [3];
  logic       a_d    [3];
  logic       b_d    [3];
  logic       busy_d [3];
  logic       done_d [3];
  logic       pass_d [3];
  logic [7:0] err_d  [3];
  logic [3:0] m_d    [3];

  int checks   = 0;
  int failures = 0;

  logic [1:0] cap_q[$];
  logic [1:0] exp_q[$];
  int         cap_busy;
  bit         cap_to;
  logic [1:0] order [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  always #5 clk = ~clk;

  // Gate model: true NOR, with per-input-pattern fault mask (index = {a,b}).
  assign y_d[0] = ~(a_d[0] | b_d[0]) ^ m_d[0][{a_d[0], b_d[0]}];
  assign y_d[1] = ~(a_d[1] | b_d[1]) ^ m_d[1][{a_d[1], b_d[1]}];
  assign y_d[2] = ~(a_d[2] | b_d[2]) ^ m_d[2][{a_d[2], b_d[2]}];

  nor_vector_driver #(.HOLD_CYCLES(1), .NUM_PASSES(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .y(y_d[0]), .a(a_d[0]), .b(b_d[0]),
    .busy(busy_d[0]), .done(done_d[0]), .pass(pass_d[0]), .err_count(err_d[0]));
  nor_vector_driver #(.HOLD_CYCLES(3), .NUM_PASSES(2)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .y(y_d[1]), .a(a_d[1]), .b(b_d[1]),
    .busy(busy_d[1]), .done(done_d[1]), .pass(pass_d[1]), .err_count(err_d[1]));
  nor_vector_driver #(.HOLD_CYCLES(1), .NUM_PASSES(100)) u_d100 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .y(y_d[2]), .a(a_d[2]), .b(b_d[2]),
    .busy(busy_d[2]), .done(done_d[2]), .pass(pass_d[2]), .err_count(err_d[2]));

  function automatic int hold_of(int s);
    return (s == 1) ? 3 : 1;
  endfunction

  function automatic int passes_of(int s);
    return (s == 0) ? 1 : ((s == 1) ? 2 : 100);
  endfunction

  function automatic void build_model(int s);
    exp_q.delete();
    for (int p = 0; p < passes_of(s); p++)
      for (int v = 0; v < 4; v++)
        for (int h = 0; h < hold_of(s); h++)
          exp_q.push_back(order[v]);
  endfunction

  function automatic int exp_err(int s, logic [3:0] m);
`ifdef NOR_DRV_CHECK_EN
    int n;
    n = $countones(m) * passes_of(s);
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  function automatic int seq_first_bad();
    int n;
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (cap_q[i] !== exp_q[i]) return i;
    if (cap_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // Leaves the bench on the negedge inside the first DRIVE cycle.
  task automatic launch(int s);
    @(negedge clk);
    st[s] = 1'b1;
    @(negedge clk);
    st[s] = 1'b0;
  endtask

  // Records {a,b} on every busy cycle until done shows or budget expires.
  task automatic capture(int s, int budget, int release_at);
    cap_q.delete();
    cap_busy = 0;
    cap_to   = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (i == release_at) st[s] = 1'b0;
      if (busy_d[s] === 1'b1) begin
        cap_q.push_back({a_d[s], b_d[s]});
        cap_busy++;
      end
      if (done_d[s] === 1'b1) begin
        cap_to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    st[s] = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      st[s]  = 1'b0;
      m_d[s] = 4'b0000;
    end
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if ({a_d[s], b_d[s], busy_d[s], done_d[s]} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: got {a,b,busy,done}=%b expected 0000", s,
                 {a_d[s], b_d[s], busy_d[s], done_d[s]});
      end
      checks++;
      if (err_d[s] !== 8'd0 || pass_d[s] !== 1'b1) begin
        failures++;
        $display("FAIL reset_err dut%0d: got err=%0d pass=%b expected err=0 pass=1",
                 s, err_d[s], pass_d[s]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int bad;
    m_d[0] = 4'b0000;
    launch(0);
    capture(0, 20, -1);
    build_model(0);
    bad = seq_first_bad();
    checks++;
    if (cap_to || bad != -1) begin
      failures++;
      $display("FAIL basic_seq: got timeout=%0d first_bad=%0d len=%0d expected 0,-1,%0d",
               cap_to, bad, cap_q.size(), exp_q.size());
    end
    checks++;
    if (cap_busy !== 4) begin
      failures++;
      $display("FAIL basic_busy: got %0d cycles expected 4", cap_busy);
    end
    checks++;
    if (done_d[0] !== 1'b1 || pass_d[0] !== 1'b1 || err_d[0] !== 8'd0 || {a_d[0], b_d[0]} !== 2'b00) begin
      failures++;
      $display("FAIL basic_done: got done=%b pass=%b err=%0d ab=%b expected 1 1 0 00",
               done_d[0], pass_d[0], err_d[0], {a_d[0], b_d[0]});
    end
  endtask

  task automatic test_stuck_and_saturate();
    m_d[0] = 4'b0001;
    launch(0);
    capture(0, 20, -1);
    checks++;
    if (cap_to || err_d[0] !== 8'(exp_err(0, 4'b0001)) || pass_d[0] !== (exp_err(0, 4'b0001) == 0)) begin
      failures++;
      $display("FAIL stuck0: got to=%0d err=%0d pass=%b expected err=%0d", cap_to, err_d[0],
               pass_d[0], exp_err(0, 4'b0001));
    end
    m_d[2] = 4'b1111;
    launch(2);
    capture(2, 600, -1);
    checks++;
    if (cap_to || cap_busy !== 400) begin
      failures++;
      $display("FAIL sat_busy: got to=%0d busy=%0d expected 400", cap_to, cap_busy);
    end
    checks++;
    if (err_d[2] !== 8'(exp_err(2, 4'b1111)) || pass_d[2] !== (exp_err(2, 4'b1111) == 0)) begin
      failures++;
      $display("FAIL saturate: got err=%0d pass=%b expected err=%0d", err_d[2], pass_d[2],
               exp_err(2, 4'b1111));
    end
  endtask

  task automatic test_hold3();
    int bad;
    m_d[1] = 4'($urandom);
    launch(1);
    capture(1, 60, -1);
    build_model(1);
    bad = seq_first_bad();
    checks++;
    if (cap_to || bad != -1 || cap_busy !== 24) begin
      failures++;
      $display("FAIL hold3_seq: got to=%0d first_bad=%0d busy=%0d expected 0,-1,24", cap_to, bad, cap_busy);
    end
    checks++;
    if (done_d[1] !== 1'b1 || err_d[1] !== 8'(exp_err(1, m_d[1]))) begin
      failures++;
      $display("FAIL hold3_err: got done=%b err=%0d expected 1 %0d (mask %b)", done_d[1], err_d[1],
               exp_err(1, m_d[1]), m_d[1]);
    end
  endtask

  task automatic test_random();
    int s, bad;
    for (int it = 0; it < 8; it++) begin
      s = int'($urandom_range(0, 2));
      m_d[s] = 4'($urandom);
      launch(s);
      capture(s, 600, -1);
      build_model(s);
      bad = seq_first_bad();
      checks++;
      if (cap_to || bad != -1) begin
        failures++;
        $display("FAIL rand_seq it%0d dut%0d: got to=%0d first_bad=%0d expected 0,-1", it, s, cap_to, bad);
      end
      checks++;
      if (err_d[s] !== 8'(exp_err(s, m_d[s])) || pass_d[s] !== (exp_err(s, m_d[s]) == 0)) begin
        failures++;
        $display("FAIL rand_err it%0d dut%0d: got err=%0d pass=%b expected %0d (mask %b)", it, s,
                 err_d[s], pass_d[s], exp_err(s, m_d[s]), m_d[s]);
      end
    end
  endtask

  task automatic test_start_held();
    int bad;
    m_d[1] = 4'b0000;
    @(negedge clk);
    st[1] = 1'b1;
    @(negedge clk);
    capture(1, 60, 20);
    build_model(1);
    bad = seq_first_bad();
    checks++;
    if (cap_to || bad != -1 || cap_busy !== 24) begin
      failures++;
      $display("FAIL start_held: got to=%0d first_bad=%0d busy=%0d expected 0,-1,24", cap_to, bad, cap_busy);
    end
  endtask

  task automatic test_done_restart();
    int bad;
    m_d[0] = 4'b0001;
    launch(0);
    capture(0, 20, -1);
    checks++;
    if (err_d[0] !== 8'(exp_err(0, 4'b0001))) begin
      failures++;
      $display("FAIL restart_pre: got err=%0d expected %0d", err_d[0], exp_err(0, 4'b0001));
    end
    m_d[0] = 4'b0000;
    launch(0);
    checks++;
    if (err_d[0] !== 8'd0 || busy_d[0] !== 1'b1 || {a_d[0], b_d[0]} !== 2'b00) begin
      failures++;
      $display("FAIL restart_clear: got err=%0d busy=%b ab=%b expected 0 1 00", err_d[0], busy_d[0],
               {a_d[0], b_d[0]});
    end
    capture(0, 20, -1);
    build_model(0);
    bad = seq_first_bad();
    checks++;
    if (cap_to || bad != -1 || pass_d[0] !== 1'b1) begin
      failures++;
      $display("FAIL restart_seq: got to=%0d first_bad=%0d pass=%b expected 0,-1,1", cap_to, bad, pass_d[0]);
    end
  endtask

  task automatic test_midrun_reset();
    int bad;
    m_d[0] = 4'b0000;
    launch(0);
    @(negedge clk);
    checks++;
    if ({a_d[0], b_d[0]} !== 2'b10 || busy_d[0] !== 1'b1) begin
      failures++;
      $display("FAIL midrun_pre: got ab=%b busy=%b expected 10 1", {a_d[0], b_d[0]}, busy_d[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_d[0], b_d[0], busy_d[0], done_d[0]} !== 4'b0000 || err_d[0] !== 8'd0) begin
      failures++;
      $display("FAIL midrun_async: got {a,b,busy,done}=%b err=%0d expected 0000 0",
               {a_d[0], b_d[0], busy_d[0], done_d[0]}, err_d[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_d[0] !== 1'b0 || done_d[0] !== 1'b0) begin
      failures++;
      $display("FAIL midrun_idle: got busy=%b done=%b expected 0 0", busy_d[0], done_d[0]);
    end
    launch(0);
    capture(0, 20, -1);
    build_model(0);
    bad = seq_first_bad();
    checks++;
    if (cap_to || bad != -1) begin
      failures++;
      $display("FAIL midrun_restart: got to=%0d first_bad=%0d expected 0,-1", cap_to, bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuck_and_saturate();
    test_hold3();
    test_random();
    test_start_held();
    test_done_restart();
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
